// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder/subtractor controller.
//
// One operation adds (SUB=0) or subtracts (SUB=1) two WIDTH-bit operands,
// processing one bit per clock, LSB first, through a single full adder.
// Subtraction is done as A + ~B + 1: the second operand is inverted on load
// and the carry flop is preset to 1.
//
// Ports:
//   CLK      in   clock, all state changes on the rising edge
//   RESET_N  in   asynchronous active-low reset
//   START    in   operation request (accepted in IDLE or DONE)
//   SUB      in   0 = A+B, 1 = A-B, sampled with START
//   A, B     in   WIDTH-bit operands, sampled with START
//   BUSY     out  high while the FSM is in RUN
//   DONE     out  one-cycle completion pulse
//   RESULT   out  WIDTH-bit sum/difference, held until the next completion
//   COUT     out  carry out of the MSB (for SUB, 1 = no borrow)
//   OVF      out  two's-complement overflow

// Single-bit full adder used as the serial arithmetic element.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cIn,
    output logic s,
    output logic cOut
);
    assign s    = a ^ b ^ cIn;
    assign cOut = (a & b) | (a & cIn) | (b & cIn);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             OVF
);

    // Counter sized to hold WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0] b_sh_q,    b_sh_d;
    logic [WIDTH-1:0] res_sh_q,  res_sh_d;
    logic             carry_q,   carry_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             cout_q,    cout_d;
    logic             ovf_q,     ovf_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic             fa_s_s;
    logic             fa_cout_s;
    logic             load_s;
    logic [WIDTH-1:0] res_full_s;

    FullAdder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cIn  (carry_q),
        .s    (fa_s_s),
        .cOut (fa_cout_s)
    );

    // A new request is taken from IDLE, or from DONE for back-to-back operation.
    assign load_s = START && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Result register contents after this cycle's sum bit is shifted in at the MSB.
    assign res_full_s = {fa_s_s, res_sh_q[WIDTH-1:1]};

    // Next-state and datapath logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_s) begin
                    a_sh_d   = A;
                    b_sh_d   = SUB ? ~B : B;
                    carry_d  = SUB;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                res_sh_d = res_full_s;
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout_s;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    // carry_q here is the carry into the MSB.
                    result_d = res_full_s;
                    cout_d   = fa_cout_s;
                    ovf_d    = carry_q ^ fa_cout_s;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign COUT   = cout_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed operations with
// a scoreboard queue of expected results, pushed at acceptance and popped on DONE.
module tb_serial_add_ctrl;

    logic       CLK;
    logic       RESET_N;
    logic       START;
    logic       SUB;
    logic [7:0] A;
    logic [7:0] B;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic       COUT;
    logic       OVF;

    typedef struct packed {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t       sb_q[$];
    int         checks;
    int         errors;
    logic [7:0] held_result;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .SUB     (SUB),
        .A       (A),
        .B       (B),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT),
        .COUT    (COUT),
        .OVF     (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        exp_t       e;
        logic [7:0] bb;
        logic [8:0] sum;
        bb     = sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
        e.res  = sum[7:0];
        e.cout = sum[8];
        e.ovf  = (a[7] == bb[7]) && (sum[7] != a[7]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive a request; the next rising edge accepts it. Operands are scrambled afterwards.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
        START = 1'b1;
        A     = a;
        B     = b;
        SUB   = sub;
        tick();
        sb_q.push_back(model(a, b, sub));
        START = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
        SUB   = 1'($urandom);
    endtask

    // Wait (bounded) for DONE, checking BUSY and held RESULT on the way, then score.
    task automatic expect_done(input int lat, input string tag);
        int   n;
        bit   got;
        exp_t e;
        n   = 0;
        got = 1'b0;
        while (!got && n < lat + 6) begin
            tick();
            n++;
            if (DONE === 1'b1) begin
                got = 1'b1;
            end else begin
                chk({tag, ":busy"}, 32'(BUSY), 32'd1);
                chk({tag, ":hold"}, 32'(RESULT), 32'(held_result));
            end
        end
        chk({tag, ":latency"}, got ? 32'(n) : 32'hFFFF_FFFF, 32'(lat));
        if (got) begin
            chk({tag, ":busy_at_done"}, 32'(BUSY), 32'd0);
            chk({tag, ":sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({tag, ":result"}, 32'(RESULT), 32'(e.res));
                chk({tag, ":cout"}, 32'(COUT), 32'(e.cout));
                chk({tag, ":ovf"}, 32'(OVF), 32'(e.ovf));
                held_result = e.res;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ":busy"}, 32'(BUSY), 32'd0);
        chk({tag, ":done"}, 32'(DONE), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ":busy"}, 32'(BUSY), 32'd0);
        chk({tag, ":done"}, 32'(DONE), 32'd0);
        chk({tag, ":result"}, 32'(RESULT), 32'd0);
        chk({tag, ":cout"}, 32'(COUT), 32'd0);
        chk({tag, ":ovf"}, 32'(OVF), 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        held_result = 8'h00;
        RESET_N     = 1'b0;
        START       = 1'b0;
        SUB         = 1'b0;
        A           = 8'h00;
        B           = 8'h00;

        // Reset state
        tick();
        tick();
        check_zero("reset");

        // Release reset and request on the very first edge afterwards
        RESET_N = 1'b1;
        start_op(8'h0F, 8'h01, 1'b0);
        chk("first_accept:busy", 32'(BUSY), 32'd1);
        expect_done(8, "add_0F_01");
        tick();
        check_idle("after_done");

        // Arithmetic boundary cases
        start_op(8'hFF, 8'h01, 1'b0);
        expect_done(8, "add_FF_01");
        tick();
        start_op(8'h7F, 8'h01, 1'b0);
        expect_done(8, "add_7F_01");
        tick();
        start_op(8'h05, 8'h07, 1'b1);
        expect_done(8, "sub_05_07");
        tick();
        start_op(8'h80, 8'h01, 1'b1);
        expect_done(8, "sub_80_01");
        tick();
        start_op(8'hA5, 8'h5A, 1'b1);
        expect_done(8, "sub_A5_5A");
        tick();
        tick();
        check_idle("idle_gap");

        // START during RUN is ignored
        start_op(8'h01, 8'h02, 1'b0);
        tick();
        tick();
        tick();
        START = 1'b1;
        A     = 8'h11;
        B     = 8'h22;
        tick();
        START = 1'b0;
        chk("ignored_start:busy", 32'(BUSY), 32'd1);
        expect_done(4, "ignore_start");
        tick();
        chk("single_done_pulse", 32'(DONE), 32'd0);
        chk("ignored_start:busy_after", 32'(BUSY), 32'd0);

        // Reset during RUN aborts, clears outputs, no DONE
        start_op(8'h55, 8'h11, 1'b0);
        tick();
        tick();
        tick();
        RESET_N = 1'b0;
        #1;
        check_zero("async_reset");
        sb_q.delete();
        held_result = 8'h00;
        tick();
        check_zero("reset_held");
        RESET_N = 1'b1;
        start_op(8'h10, 8'h20, 1'b0);
        expect_done(8, "after_reset_10_20");

        // Back-to-back: START held high through DONE
        tick();
        START = 1'b1;
        A     = 8'h33;
        B     = 8'h44;
        SUB   = 1'b0;
        tick();
        sb_q.push_back(model(8'h33, 8'h44, 1'b0));
        A = 8'h01;
        B = 8'h01;
        expect_done(8, "b2b_first");
        sb_q.push_back(model(8'h01, 8'h01, 1'b0));
        tick();
        START = 1'b0;
        chk("b2b:no_idle_busy", 32'(BUSY), 32'd1);
        chk("b2b:done_low", 32'(DONE), 32'd0);
        expect_done(8, "b2b_second");
        tick();
        check_idle("b2b_end");

        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port START, input, 1 bit: operation request, sampled on the rising edge of CLK.
REQ-005 SHALL have port SUB, input, 1 bit: 0 = A+B, 1 = A-B; sampled with START.
REQ-006 SHALL have port A, input, WIDTH bits: first operand, sampled with START.
REQ-007 SHALL have port B, input, WIDTH bits: second operand, sampled with START.
REQ-008 SHALL have port BUSY, output, 1 bit: high while an operation is in progress (state RUN).
REQ-009 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port RESULT, output, WIDTH bits: registered sum or difference.
REQ-011 SHALL have port COUT, output, 1 bit: carry out of the MSB (for SUB, 1 = no borrow).
REQ-012 SHALL have port OVF, output, 1 bit: two's-complement overflow.

Function
REQ-013 SHALL compute the result bit-serially, LSB first, using one instance of the team FullAdder (inputs a, b, cIn; outputs s, cOut), one bit per cycle.
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE; reset state is IDLE.
REQ-015 IDLE: on START=1, SHALL load the operand shift register with A and the second shift register with B (SUB=0) or ~B (SUB=1), load the carry flip-flop with SUB, clear the bit counter, and go to RUN.
REQ-016 RUN: each cycle SHALL feed the operand LSBs and the carry flop to the FullAdder, shift s into the MSB of the result shift register, shift both operand registers right by one, store cOut in the carry flop, and increment the counter.
REQ-017 SHALL stay in RUN for exactly WIDTH cycles, then go to DONE on the edge that processes bit WIDTH-1.
REQ-018 On that edge SHALL load RESULT with the complete shifted result, COUT with the final cOut, and OVF with (carry into the MSB XOR final cOut).
REQ-019 DONE state SHALL last exactly one cycle, with DONE=1, BUSY=0; then go to IDLE, unless START=1, which is accepted as in REQ-015 (back-to-back, next state RUN).
REQ-020 Latency: with START accepted at edge 0, DONE SHALL be high from edge WIDTH to edge WIDTH+1 (edges 8 to 9 for WIDTH=8).
REQ-021 START in RUN SHALL be ignored, with no effect on the operands, SUB or the counter.
REQ-022 RESULT, COUT and OVF SHALL hold their values from completion until the next completion; they SHALL NOT change during RUN.
REQ-023 A and B SHALL be allowed to change at any time after acceptance without affecting the operation in progress.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; the counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap within an operation.

Reset
REQ-025 On RESET_N=0, asynchronously: state SHALL go to IDLE; BUSY, DONE, RESULT, COUT, OVF, the counter, the carry flop and all shift registers SHALL go to 0.
REQ-026 Reset during RUN SHALL abort the operation with no DONE pulse; RESULT SHALL read 0.
REQ-027 After RESET_N rises, START SHALL be accepted on the first rising CLK edge.

Verification
REQ-028 A=8'h0F, B=8'h01, SUB=0, START at edge 0 -> BUSY for edges 1-8; DONE during edge 8-9; RESULT=8'h10, COUT=0, OVF=0.
REQ-029 A=8'hFF, B=8'h01, SUB=0 -> RESULT=8'h00, COUT=1, OVF=0; A=8'h7F, B=8'h01 -> RESULT=8'h80, COUT=0, OVF=1.
REQ-030 A=8'h05, B=8'h07, SUB=1 -> RESULT=8'hFE, COUT=0, OVF=0; A=8'h80, B=8'h01, SUB=1 -> RESULT=8'h7F, COUT=1, OVF=1.
REQ-031 START=1 with A=8'h11, B=8'h22 held at edge 4 of an operation on 8'h01+8'h02 -> ignored; RESULT=8'h03, single DONE pulse.
REQ-032 RESET_N=0 for one cycle at edge 4 of an operation -> all outputs 0, no DONE; new operation 8'h10+8'h20 then -> RESULT=8'h30 with DONE at latency 8.
REQ-033 START held high through DONE with new operands 8'h01+8'h01 -> second operation starts with no idle cycle; DONE pulses at edges 8 and 17; RESULT=8'h02.
